// File: rtl/traffic_pkg.sv
// Shared light encodings, phase state enum and light decode helpers for the
// traffic phase scheduler. PED_WALK exists only when PED_CROSSING_EN is defined.
package traffic_pkg;

  localparam logic [1:0] GREEN  = 2'b00;
  localparam logic [1:0] YELLOW = 2'b01;
  localparam logic [1:0] RED    = 2'b10;

  typedef enum logic [2:0] {
    GREEN_A  = 3'd0,
    YELLOW_A = 3'd1,
    RED_AB   = 3'd2,
    GREEN_B  = 3'd3,
    YELLOW_B = 3'd4,
    RED_BA   = 3'd5
`ifdef PED_CROSSING_EN
    , PED_WALK = 3'd6
`endif
  } phase_e;

  function automatic logic [1:0] light_a(input phase_e p);
    case (p)
      GREEN_A:  light_a = GREEN;
      YELLOW_A: light_a = YELLOW;
      default:  light_a = RED;
    endcase
  endfunction

  function automatic logic [1:0] light_b(input phase_e p);
    case (p)
      GREEN_B:  light_b = GREEN;
      YELLOW_B: light_b = YELLOW;
      default:  light_b = RED;
    endcase
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Per-phase dwell counter: zero in the first cycle after restart or reset,
// then counts up one per cycle and saturates at 255.
module phase_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       restart,
  output logic [7:0] count
);

  logic [7:0] r_count;

  always_ff @(posedge clk) begin
    if (rst || restart) begin
      r_count <= '0;
    end else if (r_count != '1) begin
      r_count <= r_count + 8'd1;
    end
  end

  assign count = r_count;

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Two-street traffic light phase scheduler with min/max green, yellow and
// all-red dwells. Optional pedestrian walk phase under macro PED_CROSSING_EN.
module traffic_phase_scheduler
  import traffic_pkg::*;
#(
  parameter int unsigned MIN_GREEN = 4,
  parameter int unsigned MAX_GREEN = 10,
  parameter int unsigned YELLOW_T  = 2,
  parameter int unsigned ALLRED_T  = 1,
  parameter int unsigned WALK_T    = 3
) (
  input  logic       clk,
  input  logic       rst,
`ifdef PED_CROSSING_EN
  input  logic       ped_req,
  output logic       walk,
`endif
  input  logic       TA,
  input  logic       TB,
  output logic [1:0] LA,
  output logic [1:0] LB,
  output logic [2:0] phase
);

  if (MIN_GREEN < 1 || MIN_GREEN > 255 || MAX_GREEN < MIN_GREEN || MAX_GREEN > 255 ||
      YELLOW_T < 1 || YELLOW_T > 255 || ALLRED_T < 1 || ALLRED_T > 255 ||
      WALK_T < 1 || WALK_T > 255) begin : g_bad_cfg
    $error("traffic_phase_scheduler: dwell parameter out of range");
  end

  localparam logic [7:0] C_MIN_LAST  = 8'(MIN_GREEN - 1);
  localparam logic [7:0] C_MAX_LAST  = 8'(MAX_GREEN - 1);
  localparam logic [7:0] C_YEL_LAST  = 8'(YELLOW_T - 1);
  localparam logic [7:0] C_RED_LAST  = 8'(ALLRED_T - 1);
`ifdef PED_CROSSING_EN
  localparam logic [7:0] C_WALK_LAST = 8'(WALK_T - 1);
`endif

  phase_e     r_state;
  phase_e     w_next;
  logic [1:0] r_la;
  logic [1:0] r_lb;
  logic [7:0] w_timer;
  logic       w_restart;
`ifdef PED_CROSSING_EN
  logic       r_ped_pend;
  logic       r_walk_to_b;
  logic       r_walk;
`endif

  phase_timer u_timer (
    .clk     (clk),
    .rst     (rst),
    .restart (w_restart),
    .count   (w_timer)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      GREEN_A:  if (TB && w_timer >= C_MIN_LAST && (!TA || w_timer >= C_MAX_LAST)) w_next = YELLOW_A;
      YELLOW_A: if (w_timer >= C_YEL_LAST) w_next = RED_AB;
`ifdef PED_CROSSING_EN
      RED_AB:   if (w_timer >= C_RED_LAST) w_next = r_ped_pend ? PED_WALK : GREEN_B;
`else
      RED_AB:   if (w_timer >= C_RED_LAST) w_next = GREEN_B;
`endif
      GREEN_B:  if (TA && w_timer >= C_MIN_LAST && (!TB || w_timer >= C_MAX_LAST)) w_next = YELLOW_B;
      YELLOW_B: if (w_timer >= C_YEL_LAST) w_next = RED_BA;
`ifdef PED_CROSSING_EN
      RED_BA:   if (w_timer >= C_RED_LAST) w_next = r_ped_pend ? PED_WALK : GREEN_A;
      PED_WALK: if (w_timer >= C_WALK_LAST) w_next = r_walk_to_b ? GREEN_B : GREEN_A;
`else
      RED_BA:   if (w_timer >= C_RED_LAST) w_next = GREEN_A;
`endif
      default:  w_next = GREEN_A;
    endcase
  end

  // Restarting the timer on the transition edge makes it read 0 in a new state's first cycle.
  assign w_restart = (w_next != r_state);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= GREEN_A;
      r_la    <= GREEN;
      r_lb    <= RED;
`ifdef PED_CROSSING_EN
      r_ped_pend  <= 1'b0;
      r_walk_to_b <= 1'b0;
      r_walk      <= 1'b0;
`endif
    end else begin
      r_state <= w_next;
      r_la    <= light_a(w_next);
      r_lb    <= light_b(w_next);
`ifdef PED_CROSSING_EN
      r_walk  <= (w_next == PED_WALK);
      // Entry into the walk consumes the flag; a request in that same cycle re-arms it.
      if (w_restart && w_next == PED_WALK) begin
        r_ped_pend  <= ped_req;
        r_walk_to_b <= (r_state == RED_AB);
      end else if (ped_req) begin
        r_ped_pend  <= 1'b1;
      end
`endif
    end
  end

  assign LA    = r_la;
  assign LB    = r_lb;
  assign phase = r_state;
`ifdef PED_CROSSING_EN
  assign walk  = r_walk;
`endif

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Scoreboard bench for traffic_phase_scheduler: a reference model pushes the
// expected lights/phase per driven cycle; each scenario task pops and compares.
module tb_traffic_phase_scheduler;

  localparam int MIN_G = 4;
  localparam int MAX_G = 10;
  localparam int YEL   = 2;
  localparam int ALLR  = 1;
  localparam int WLK   = 3;

  typedef struct packed {
    logic [1:0] la;
    logic [1:0] lb;
    logic [2:0] ph;
    logic       wk;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       TA = 1'b0;
  logic       TB = 1'b0;
  logic       ped_req = 1'b0;
  logic       walk_o;
  logic [1:0] LA;
  logic [1:0] LB;
  logic [2:0] phase;

  int checks = 0;
  int failures = 0;

  exp_t exp_q[$];
  int   m_state = 0;
  int   m_timer = 0;
  bit   m_pend = 0;
  bit   m_to_b = 0;
  bit   last_rst = 0;

  traffic_phase_scheduler #(
    .MIN_GREEN (MIN_G),
    .MAX_GREEN (MAX_G),
    .YELLOW_T  (YEL),
    .ALLRED_T  (ALLR),
    .WALK_T    (WLK)
  ) dut (
    .clk     (clk),
    .rst     (rst),
`ifdef PED_CROSSING_EN
    .ped_req (ped_req),
    .walk    (walk_o),
`endif
    .TA      (TA),
    .TB      (TB),
    .LA      (LA),
    .LB      (LB),
    .phase   (phase)
  );

`ifndef PED_CROSSING_EN
  assign walk_o = 1'b0;
`endif

  always #5 clk = ~clk;

  function automatic exp_t model_out(input int st);
    exp_t e;
    e.ph = 3'(st);
    e.wk = (st == 6);
    e.la = (st == 0) ? 2'b00 : (st == 1) ? 2'b01 : 2'b10;
    e.lb = (st == 3) ? 2'b00 : (st == 4) ? 2'b01 : 2'b10;
    return e;
  endfunction

  // Drive one cycle's inputs on the falling edge, advance the model, then wait past the rising edge.
  task automatic drive_cycle(input bit ta, input bit tb, input bit r, input bit pr);
    int nxt;
    @(negedge clk);
    TA = ta; TB = tb; rst = r; ped_req = pr;
    last_rst = r;
    if (r) begin
      m_state = 0; m_timer = 0; m_pend = 0; m_to_b = 0;
    end else begin
      nxt = m_state;
      case (m_state)
        0: if (tb && m_timer + 1 >= MIN_G && (!ta || m_timer + 1 >= MAX_G)) nxt = 1;
        1: if (m_timer + 1 == YEL) nxt = 2;
        2: if (m_timer + 1 == ALLR) nxt = m_pend ? 6 : 3;
        3: if (ta && m_timer + 1 >= MIN_G && (!tb || m_timer + 1 >= MAX_G)) nxt = 4;
        4: if (m_timer + 1 == YEL) nxt = 5;
        5: if (m_timer + 1 == ALLR) nxt = m_pend ? 6 : 0;
        6: if (m_timer + 1 == WLK) nxt = m_to_b ? 3 : 0;
        default: nxt = 0;
      endcase
`ifdef PED_CROSSING_EN
      if (nxt == 6 && m_state != 6) begin
        m_to_b = (m_state == 2);
        m_pend = pr;
      end else if (pr) m_pend = 1;
`else
      m_pend = 0;
`endif
      if (nxt != m_state) m_timer = 0;
      else if (m_timer < 255) m_timer++;
      m_state = nxt;
    end
    exp_q.push_back(model_out(m_state));
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    drive_cycle(0, 0, 1, 0);
    e = exp_q.pop_front();
    drive_cycle(0, 0, 1, 0);
    e = exp_q.pop_front();
    checks++;
    if (LA !== 2'b00 || LB !== 2'b10 || phase !== 3'd0 || walk_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: LA=%b LB=%b phase=%0d walk=%b want 00 10 0 0", LA, LB, phase, walk_o);
    end
    for (int i = 0; i < 20; i++) begin
      drive_cycle(0, 0, 0, 0);
      e = exp_q.pop_front();
      checks++;
      if ({LA, LB, phase} !== {2'b00, 2'b10, 3'd0} || {LA, LB, phase, walk_o} !== e) begin
        failures++;
        $display("FAIL reset_hold[%0d]: LA=%b LB=%b phase=%0d want LA=00 LB=10 phase=0", i, LA, LB, phase);
      end
    end
  endtask

  task automatic test_uncontested();
    exp_t e;
    logic [2:0] seq [8];
    seq = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd2, 3'd3};
    drive_cycle(0, 1, 1, 0);
    e = exp_q.pop_front();
    for (int c = 1; c <= 8; c++) begin
      if (c > 1) begin
        drive_cycle(0, 1, 0, 0);
        e = exp_q.pop_front();
        checks++;
        if ({LA, LB, phase, walk_o} !== e) begin
          failures++;
          $display("FAIL uncontested_sb[%0d]: got %b want %b", c, {LA, LB, phase, walk_o}, e);
        end
      end
      checks++;
      if (phase !== seq[c-1]) begin
        failures++;
        $display("FAIL uncontested_phase[cycle %0d]: phase=%0d want %0d", c, phase, seq[c-1]);
      end
    end
    checks++;
    if (LB !== 2'b00 || LA !== 2'b10) begin
      failures++;
      $display("FAIL uncontested_cycle8: LA=%b LB=%b want LA=10 LB=00", LA, LB);
    end
  endtask

  task automatic test_max_green();
    exp_t e;
    int run_len;
    int runs_seen;
    logic [2:0] prev;
    drive_cycle(1, 1, 1, 0);
    e = exp_q.pop_front();
    prev = phase;
    run_len = 1;
    runs_seen = 0;
    for (int i = 0; i < 80; i++) begin
      drive_cycle(1, 1, 0, 0);
      e = exp_q.pop_front();
      checks++;
      if ({LA, LB, phase, walk_o} !== e) begin
        failures++;
        $display("FAIL max_green_sb[%0d]: got %b want %b", i, {LA, LB, phase, walk_o}, e);
      end
      if (phase === prev) run_len++;
      else begin
        if (prev === 3'd0 || prev === 3'd3) begin
          runs_seen++;
          checks++;
          if (run_len !== MAX_G) begin
            failures++;
            $display("FAIL max_green_dwell[phase %0d]: dwell=%0d want %0d", prev, run_len, MAX_G);
          end
        end
        run_len = 1;
        prev = phase;
      end
    end
    checks++;
    if (runs_seen < 5) begin
      failures++;
      $display("FAIL max_green_period: green runs=%0d want >=5", runs_seen);
    end
  endtask

  task automatic test_mid_yellow_reset();
    exp_t e;
    drive_cycle(0, 1, 1, 0);
    e = exp_q.pop_front();
    for (int c = 2; c <= 6; c++) begin
      drive_cycle(0, 1, 0, 0);
      e = exp_q.pop_front();
    end
    checks++;
    if (phase !== 3'd1 || LA !== 2'b01) begin
      failures++;
      $display("FAIL mid_yellow_setup: phase=%0d LA=%b want 1 01", phase, LA);
    end
    drive_cycle(0, 1, 1, 0);
    e = exp_q.pop_front();
    checks++;
    if (phase !== 3'd0 || LA !== 2'b00 || LB !== 2'b10) begin
      failures++;
      $display("FAIL mid_yellow_reset: phase=%0d LA=%b LB=%b want 0 00 10", phase, LA, LB);
    end
    // A fresh timer means GREEN_A must again last exactly MIN_G cycles.
    for (int c = 2; c <= 6; c++) begin
      drive_cycle(0, 1, 0, 0);
      e = exp_q.pop_front();
      checks++;
      if ({LA, LB, phase, walk_o} !== e || phase !== ((c <= MIN_G) ? 3'd0 : 3'd1)) begin
        failures++;
        $display("FAIL mid_yellow_regreen[%0d]: phase=%0d want %0d", c, phase, (c <= MIN_G) ? 0 : 1);
      end
    end
  endtask

`ifdef PED_CROSSING_EN
  task automatic test_ped();
    exp_t e;
    logic [2:0] seq [11];
    seq = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd2, 3'd6, 3'd6, 3'd6, 3'd3};
    drive_cycle(0, 1, 1, 0);
    e = exp_q.pop_front();
    for (int c = 2; c <= 11; c++) begin
      drive_cycle(0, 1, 0, (c == 2));
      e = exp_q.pop_front();
      checks++;
      if ({LA, LB, phase, walk_o} !== e || phase !== seq[c-1] || walk_o !== (seq[c-1] == 3'd6)) begin
        failures++;
        $display("FAIL ped_walk[cycle %0d]: phase=%0d walk=%b LA=%b LB=%b want phase %0d", c, phase, walk_o, LA, LB, seq[c-1]);
      end
    end
  endtask
`endif

  task automatic test_random_safety();
    exp_t e;
    int ylen;
    logic [2:0] prev;
    bit r;
    ylen = 0;
    prev = 3'd0;
    for (int i = 0; i < 10000; i++) begin
      r = ($urandom_range(0, 99) == 0);
      drive_cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, r, $urandom_range(0, 15) == 0);
      e = exp_q.pop_front();
      checks++;
      if ({LA, LB, phase, walk_o} !== e) begin
        failures++;
        $display("FAIL random_sb[%0d]: got %b want %b", i, {LA, LB, phase, walk_o}, e);
      end
      checks++;
      if (LA !== 2'b10 && LB !== 2'b10) begin
        failures++;
        $display("FAIL random_safety[%0d]: LA=%b LB=%b both non-red", i, LA, LB);
      end
      if ((prev === 3'd1 || prev === 3'd4) && phase !== prev && !last_rst) begin
        checks++;
        if (ylen !== YEL) begin
          failures++;
          $display("FAIL random_yellow_dwell[%0d]: dwell=%0d want %0d", i, ylen, YEL);
        end
      end
      if (phase === 3'd1 || phase === 3'd4) ylen = (phase === prev) ? ylen + 1 : 1;
      else ylen = 0;
      prev = phase;
    end
  endtask

  initial begin
    test_reset();
    test_uncontested();
    test_max_green();
    test_mid_yellow_reset();
`ifdef PED_CROSSING_EN
    test_ped();
`endif
    test_random_safety();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
